// File: rtl/controle_exibe_sequencia_if.sv
// Playback bus between the game control unit/sequence memory (master) and the LED sequencer (slave).
// Carries the start/abort requests, the latched limit, the memory read path and the display/status outputs.
interface controle_exibe_sequencia_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              iniciar;
  logic              abortar;
  logic [ADDR_W-1:0] limite;
  logic [DATA_W-1:0] dado_memoria;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] leds;
  logic              mostrando;
  logic              pronto;
  logic [3:0]        db_estado;

  modport master (
    output iniciar, abortar, limite, dado_memoria,
    input  endereco, leds, mostrando, pronto, db_estado
  );

  modport slave (
    input  iniciar, abortar, limite, dado_memoria,
    output endereco, leds, mostrando, pronto, db_estado
  );
endinterface

// File: rtl/controle_exibe_sequencia.sv
// Plays memory entries 0..limit on the LEDs: each lit ON_CYCLES, then blanked OFF_CYCLES, then a pronto pulse.
// Latency (L+1)*(1+ON+OFF)+L cycles from CARREGA to FIM; no backpressure, iniciar ignored while busy.
module controle_exibe_sequencia #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int ON_CYCLES  = 500,
  parameter int OFF_CYCLES = 250
) (
  input logic                    clock,
  input logic                    reset,
  controle_exibe_sequencia_if.slave bus
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC) + 1;
  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CARREGA = 3'd1,
    MOSTRA  = 3'd2,
    APAGA   = 3'd3,
    AVANCA  = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t           estado, estadoNext;
  logic [TMR_W-1:0]  timer, timerNext;
  logic [ADDR_W-1:0] endereco, enderecoNext;
  logic [DATA_W-1:0] leds, ledsNext;
  logic [ADDR_W-1:0] limReg, limRegNext;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= IDLE;
      timer    <= '0;
      endereco <= '0;
      leds     <= '0;
      limReg   <= '0;
    end else begin
      estado   <= estadoNext;
      timer    <= timerNext;
      endereco <= enderecoNext;
      leds     <= ledsNext;
      limReg   <= limRegNext;
    end
  end

  always_comb begin
    estadoNext   = estado;
    timerNext    = '0;
    enderecoNext = endereco;
    ledsNext     = leds;
    limRegNext   = limReg;

    case (estado)
      IDLE: begin
        enderecoNext = '0;
        ledsNext     = '0;
        if (bus.iniciar) begin
          limRegNext  = bus.limite;
          estadoNext  = CARREGA;
        end
      end
      CARREGA: begin
        ledsNext   = bus.dado_memoria;
        estadoNext = MOSTRA;
      end
      MOSTRA: begin
        if (timer == ON_LAST) begin
          ledsNext   = '0;
          estadoNext = APAGA;
        end else begin
          timerNext = timer + 1'b1;
        end
      end
      APAGA: begin
        ledsNext = '0;
        if (timer == OFF_LAST) begin
          estadoNext = (endereco == limReg) ? FIM : AVANCA;
        end else begin
          timerNext = timer + 1'b1;
        end
      end
      AVANCA: begin
        enderecoNext = endereco + ADDR_W'(1);
        estadoNext   = CARREGA;
      end
      FIM: begin
        enderecoNext = '0;
        ledsNext     = '0;
        estadoNext   = IDLE;
      end
      default: begin
        enderecoNext = '0;
        ledsNext     = '0;
        estadoNext   = IDLE;
      end
    endcase

    // Abort overrides every normal transition, but an idle unit simply ignores it.
    if (bus.abortar && (estado != IDLE)) begin
      estadoNext   = IDLE;
      timerNext    = '0;
      enderecoNext = '0;
      ledsNext     = '0;
    end
  end

  always_comb begin
    case (estado)
      IDLE:    bus.db_estado = 4'd0;
      CARREGA: bus.db_estado = 4'd1;
      MOSTRA:  bus.db_estado = 4'd2;
      APAGA:   bus.db_estado = 4'd3;
      AVANCA:  bus.db_estado = 4'd4;
      FIM:     bus.db_estado = 4'd5;
      default: bus.db_estado = 4'd9;
    endcase
  end

  assign bus.endereco  = endereco;
  assign bus.leds      = leds;
  assign bus.pronto    = (estado == FIM);
  assign bus.mostrando = (estado == CARREGA) || (estado == MOSTRA) ||
                         (estado == APAGA)   || (estado == AVANCA);

endmodule
